// File: rtl/avalon_st_packet_fifo.sv
// Avalon-ST sink-to-source FIFO with packet framing checks and optional store-and-forward.
// Show-ahead: out_* always presents the head entry; fill_level/almost_full are registered.
module avalon_st_packet_fifo #(
  parameter int DATA_W    = 256,
  parameter int EMPTY_W   = 5,
  parameter int CHANNEL_W = 1,
  parameter int DEPTH     = 16,
  parameter int STORE_FWD = 0,
  parameter int AFULL_TH  = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic [EMPTY_W-1:0]       in_empty,
  input  logic [CHANNEL_W-1:0]     in_channel,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [EMPTY_W-1:0]       out_empty,
  output logic [CHANNEL_W-1:0]     out_channel,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     almost_full,
  output logic                     framing_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic                 sop;
    logic                 eop;
    logic [EMPTY_W-1:0]   empty;
    logic [CHANNEL_W-1:0] channel;
  } entry_t;

  typedef enum logic {FRAME_IDLE, FRAME_BODY} frame_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level, level_nxt, eop_count, eop_count_nxt;
  logic            is_full, is_empty, wr_en, rd_en, wr_eop, rd_eop;
  logic            released, gate;
  frame_t          frame_q, frame_d;
  logic            ferr_d;

  assign is_full  = (level == FULL_LVL);
  assign is_empty = (level == '0);
  assign in_ready = !is_full && !reset;
  assign wr_en    = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign rd_en    = out_valid && out_ready;
  assign wr_eop   = wr_en && in_endofpacket;
  assign rd_eop   = rd_en && head.eop;

  // Store-and-forward releases a packet once its eop is stored, or when full so
  // packets longer than the FIFO cannot deadlock; a released packet keeps flowing.
  always_comb begin
    gate = 1'b1;
    if (STORE_FWD != 0)
      gate = (eop_count != '0) || is_full || released;
  end

  assign out_valid         = !is_empty && gate;
  assign out_data          = head.data;
  assign out_startofpacket = head.sop;
  assign out_endofpacket   = head.eop;
  assign out_empty         = head.empty;
  assign out_channel       = head.channel;
  assign fill_level        = level;

  always_comb begin
    level_nxt = level;
    if (wr_en && !rd_en)
      level_nxt = level + LW'(1);
    else if (!wr_en && rd_en)
      level_nxt = level - LW'(1);
  end

  always_comb begin
    eop_count_nxt = eop_count;
    if (wr_eop && !rd_eop)
      eop_count_nxt = eop_count + LW'(1);
    else if (!wr_eop && rd_eop)
      eop_count_nxt = eop_count - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {in_data, in_startofpacket, in_endofpacket, in_empty, in_channel};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      eop_count   <= '0;
      almost_full <= 1'b0;
      released    <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + AW'(1);
      level       <= level_nxt;
      eop_count   <= eop_count_nxt;
      almost_full <= (int'(level_nxt) >= AFULL_TH);
      // The release gate is only re-armed when a packet's eop leaves the FIFO.
      if (rd_eop)
        released <= 1'b0;
      else if (out_valid)
        released <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q     <= FRAME_IDLE;
      framing_err <= 1'b0;
    end else begin
      frame_q     <= frame_d;
      framing_err <= ferr_d;
    end
  end

  // Framing violations are flagged but the offending word is stored unchanged.
  always_comb begin
    frame_d = frame_q;
    ferr_d  = 1'b0;
    if (wr_en) begin
      ferr_d = (frame_q == FRAME_BODY) ? in_startofpacket : !in_startofpacket;
      if (in_endofpacket)
        frame_d = FRAME_IDLE;
      else if (in_startofpacket)
        frame_d = FRAME_BODY;
    end
  end

endmodule

// File: tb/tb_avalon_st_packet_fifo.sv
// Scoreboard bench: one cut-through and one store-and-forward FIFO (DEPTH=4) fed the same
// words; a per-FIFO queue model predicts output order, valid gating, level and framing errors.
module tb_avalon_st_packet_fifo;

  localparam int DW    = 32;
  localparam int EW    = 2;
  localparam int CW    = 2;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam int LW    = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [CW-1:0] ch;
  } word_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_sop, in_eop;
  logic [EW-1:0] in_empty;
  logic [CW-1:0] in_channel;
  logic [1:0]    in_valid, in_ready, out_valid, out_ready, out_sop, out_eop;
  logic [1:0]    almost_full, framing_err;
  logic [DW-1:0] out_data    [2];
  logic [EW-1:0] out_empty   [2];
  logic [CW-1:0] out_channel [2];
  logic [LW-1:0] fill_level  [2];

  int    vectors     = 0;
  int    miscompares = 0;
  int    mode        = 0;
  word_t expq [2][$];
  bit    in_pkt   [2];
  bit    out_mid  [2];
  bit    exp_ferr [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    avalon_st_packet_fifo #(
      .DATA_W(DW), .EMPTY_W(EW), .CHANNEL_W(CW), .DEPTH(DEPTH),
      .STORE_FWD(g), .AFULL_TH(AFULL)
    ) dut (
      .clk(clk),
      .reset(reset),
      .in_data(in_data),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .in_startofpacket(in_sop),
      .in_endofpacket(in_eop),
      .in_empty(in_empty),
      .in_channel(in_channel),
      .out_data(out_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_startofpacket(out_sop[g]),
      .out_endofpacket(out_eop[g]),
      .out_empty(out_empty[g]),
      .out_channel(out_channel[g]),
      .fill_level(fill_level[g]),
      .almost_full(almost_full[g]),
      .framing_err(framing_err[g])
    );
  end

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < 2; k++) begin
      expq[k].delete();
      in_pkt[k]   = 1'b0;
      out_mid[k]  = 1'b0;
      exp_ferr[k] = 1'b0;
    end
  endtask

  // Status first (reflects edges so far), then account for transfers at the coming edge.
  task automatic monitorStep(int k);
    word_t w;
    bit    has_eop = 1'b0;
    bit    ev;
    int    sz = expq[k].size();
    for (int i = 0; i < sz; i++)
      if (expq[k][i].eop) has_eop = 1'b1;
    ev = (sz != 0) && (k == 0 || has_eop || sz == DEPTH || out_mid[k]);
    checkOutput($sformatf("out_valid[%0d]", k), out_valid[k], ev);
    checkOutput($sformatf("fill_level[%0d]", k), fill_level[k], sz);
    checkOutput($sformatf("almost_full[%0d]", k), almost_full[k], sz >= AFULL);
    checkOutput($sformatf("framing_err[%0d]", k), framing_err[k], exp_ferr[k]);
    exp_ferr[k] = 1'b0;
    if (out_valid[k] && out_ready[k]) begin
      if (sz == 0) begin
        checkOutput($sformatf("read_on_empty[%0d]", k), out_valid[k], 0);
      end else begin
        w = expq[k].pop_front();
        checkOutput($sformatf("out_data[%0d]", k), out_data[k], w.data);
        checkOutput($sformatf("out_sop[%0d]", k), out_sop[k], w.sop);
        checkOutput($sformatf("out_eop[%0d]", k), out_eop[k], w.eop);
        checkOutput($sformatf("out_empty[%0d]", k), out_empty[k], w.empty);
        checkOutput($sformatf("out_channel[%0d]", k), out_channel[k], w.ch);
        out_mid[k] = !w.eop;
      end
    end
    if (in_valid[k] && in_ready[k]) begin
      w = {in_data, in_sop, in_eop, in_empty, in_channel};
      exp_ferr[k] = in_pkt[k] ? in_sop : !in_sop;
      if (in_eop)      in_pkt[k] = 1'b0;
      else if (in_sop) in_pkt[k] = 1'b1;
      expq[k].push_back(w);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      monitorStep(0);
      monitorStep(1);
    end
  end

  initial begin
    out_ready = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready = 2'b00;
        1:       out_ready = 2'b11;
        default: out_ready = 2'($urandom);
      endcase
    end
  end

  task automatic idleCycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one word to both FIFOs; each drops valid independently once it accepts.
  task automatic applyStimulus(logic [DW-1:0] d, logic s, logic e, logic [EW-1:0] em, logic [CW-1:0] ch);
    logic [1:0] acc;
    in_data    = d;
    in_sop     = s;
    in_eop     = e;
    in_empty   = em;
    in_channel = ch;
    in_valid   = 2'b11;
    for (int c = 0; c < 200 && in_valid != 2'b00; c++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      in_valid = in_valid & ~acc;
    end
    if (in_valid != 2'b00) begin
      checkOutput("write_timeout", in_valid, 0);
      in_valid = 2'b00;
    end
  endtask

  task automatic drain();
    mode = 1;
    for (int c = 0; c < 100 && (expq[0].size() + expq[1].size()) != 0; c++)
      @(posedge clk);
    @(negedge clk);
    checkOutput("drain_level", {fill_level[0], fill_level[1]}, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int len;
    logic s, e;
    reset    = 1'b1;
    in_valid = 2'b00;
    in_data  = '0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_empty = '0;
    in_channel = '0;
    resetModel();
    #2;
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_fill0", fill_level[0], 0);
    checkOutput("reset_fill1", fill_level[1], 0);
    checkOutput("reset_almost_full", almost_full, 0);
    checkOutput("reset_framing_err", framing_err, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_release", in_ready, 2'b11);
    @(posedge clk);
    #1;

    // Two-word packet straight through
    mode = 1;
    idleCycles(1);
    applyStimulus(32'hA1, 1'b1, 1'b0, 2'd0, 2'd1);
    applyStimulus(32'hA2, 1'b0, 1'b1, 2'd3, 2'd1);
    drain();

    // Fill to DEPTH with the sink stalled, then release the sink mid-packet
    mode = 0;
    idleCycles(1);
    applyStimulus(32'hB1, 1'b1, 1'b0, 2'd0, 2'd0);
    for (int i = 2; i <= 4; i++)
      applyStimulus(32'hB0 + DW'(i), 1'b0, 1'b0, 2'd0, 2'd0);
    @(negedge clk);
    checkOutput("in_ready_when_full", in_ready, 0);
    checkOutput("full_level0", fill_level[0], DEPTH);
    checkOutput("full_level1", fill_level[1], DEPTH);
    @(posedge clk);
    #1;
    fork
      begin idleCycles(3); mode = 1; end
    join_none
    applyStimulus(32'hB5, 1'b0, 1'b0, 2'd0, 2'd0);
    applyStimulus(32'hB6, 1'b0, 1'b1, 2'd2, 2'd0);
    drain();

    // Packet with idle gaps: store-and-forward must wait for eop
    applyStimulus(32'hC1, 1'b1, 1'b0, 2'd0, 2'd2);
    idleCycles(2);
    applyStimulus(32'hC2, 1'b0, 1'b0, 2'd0, 2'd2);
    idleCycles(2);
    applyStimulus(32'hC3, 1'b0, 1'b1, 2'd1, 2'd2);
    drain();

    // Concurrent read and write around level 2 with pointer wrap
    mode = 0;
    idleCycles(1);
    applyStimulus(32'hD0, 1'b1, 1'b0, 2'd0, 2'd3);
    applyStimulus(32'hD1, 1'b0, 1'b0, 2'd0, 2'd3);
    mode = 1;
    for (int i = 0; i < 10; i++)
      applyStimulus(32'hD2 + DW'(i), 1'b0, i == 9, 2'd0, 2'd3);
    drain();

    // Second sop inside a packet
    applyStimulus(32'hE1, 1'b1, 1'b0, 2'd0, 2'd1);
    applyStimulus(32'hE2, 1'b1, 1'b0, 2'd0, 2'd1);
    applyStimulus(32'hE3, 1'b0, 1'b1, 2'd0, 2'd1);
    drain();

    // Randomised packets, random sink backpressure, occasional framing faults
    mode = 2;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        s = (j == 0);
        e = (j == len - 1);
        if ($urandom_range(0, 9) == 0) s = !s;
        if ($urandom_range(0, 9) == 0) e = !e;
        applyStimulus(DW'($urandom), s, e, EW'($urandom), CW'($urandom));
        idleCycles($urandom_range(0, 2));
      end
    end
    applyStimulus(32'hF0, 1'b1, 1'b1, 2'd0, 2'd0);
    drain();

    // Reset in the middle of a packet
    mode = 0;
    idleCycles(1);
    applyStimulus(32'h51, 1'b1, 1'b0, 2'd0, 2'd0);
    applyStimulus(32'h52, 1'b0, 1'b0, 2'd0, 2'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_fill0", fill_level[0], 0);
    checkOutput("midreset_fill1", fill_level[1], 0);
    checkOutput("midreset_in_ready", in_ready, 0);
    resetModel();
    idleCycles(2);
    #2 reset = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_midreset", in_ready, 2'b11);
    @(posedge clk);
    #1;
    mode = 1;
    applyStimulus(32'h61, 1'b1, 1'b0, 2'd0, 2'd1);
    applyStimulus(32'h62, 1'b0, 1'b1, 2'd1, 2'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
